// File: rtl/dsmod_feeder_pkg.sv
// Shared types for the delta-sigma modulator feeder: scheduler states and
// FIFO pointer sizing.
package dsmod_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    RAMP_UP,
    RAMP_DOWN
  } state_t;

  // One extra pointer bit distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsmod_feeder_sync_fifo.sv
// Small synchronous FIFO for signed samples; asynchronous active-low clear,
// synchronous flush, combinational head read.
module sync_fifo
  import dsmod_feeder_pkg::*;
#(
  parameter int n = 16,
  parameter int d = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                flush,
  input  logic                push,
  input  logic signed [n-1:0] din,
  input  logic                pop,
  output logic signed [n-1:0] dout,
  output logic                full,
  output logic                empty
);
  localparam int PW = ptr_w(d);

  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic signed [n-1:0] mem [d];
  logic                do_push, do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-2:0]] <= din;
  end

  assign dout  = mem[rd_ptr[PW-2:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

endmodule

// File: rtl/dsmod_feeder.sv
// Sample scheduler feeding a first-order delta-sigma modulator: one FIFO sample
// per osr clocks, with start/stop sequencing. Macro DSMOD_FEEDER_RAMP_EN adds
// shift-based soft ramp states.
module dsmod_feeder
  import dsmod_feeder_pkg::*;
#(
  parameter int n   = 16,
  parameter int osr = 64,
  parameter int d   = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic signed [n-1:0] in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [n-1:0] mod_in,
  output logic                mod_clr,
  output logic                strobe,
  output logic                underrun,
  output logic                busy
);
  localparam int CW = (osr > 2) ? $clog2(osr) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(osr - 1);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic                boundary, push, pop, flush, full, empty;
  logic signed [n-1:0] head, sample_nx;

`ifdef DSMOD_FEEDER_RAMP_EN
  localparam int KW = $clog2(n);
  localparam logic [KW-1:0] K_MAX = KW'(n - 1);

  logic [KW-1:0]       k, k_nx, ksh;
  logic signed [n-1:0] cur;

  function automatic logic signed [n-1:0] ramp_shift(input logic signed [n-1:0] s,
                                                     input logic [KW-1:0] sh);
    return s >>> sh;
  endfunction
`endif

  sync_fifo #(.n(n), .d(d)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .push  (push),
    .din   (in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign boundary = (state != IDLE) && (cnt == CNT_LAST);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = boundary && !empty;
  assign flush    = (state != IDLE) && (state_nx == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    case (state)
`ifdef DSMOD_FEEDER_RAMP_EN
      IDLE:      if (en) state_nx = RAMP_UP;
      RUN:       if (!en) state_nx = RAMP_DOWN;
      RAMP_UP: begin
        if (!en) state_nx = RAMP_DOWN;
        else if (boundary && k == '0) state_nx = RUN;
      end
      RAMP_DOWN: begin
        if (en) state_nx = RAMP_UP;
        else if (boundary && k == K_MAX) state_nx = IDLE;
      end
`else
      IDLE:      if (en) state_nx = RUN;
      RUN:       if (!en) state_nx = DRAIN;
`endif
      DRAIN: begin
        if (en) state_nx = RUN;
        else if (boundary && empty) state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

`ifdef DSMOD_FEEDER_RAMP_EN
  // Ramp-up shows the sample at the current k, ramp-down at the next k,
  // so the two sequences mirror each other around RUN.
  always_comb begin
    k_nx = k;
    ksh  = k;
    case (state)
      IDLE:      k_nx = K_MAX;
      RAMP_UP:   if (boundary && k != '0) k_nx = k - KW'(1);
      RAMP_DOWN: begin
        if (boundary && k != K_MAX) begin
          k_nx = k + KW'(1);
          ksh  = k + KW'(1);
        end
      end
      default:   ;
    endcase
  end

  assign sample_nx = pop ? head : cur;
`else
  assign sample_nx = pop ? head : mod_in;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      mod_in   <= '0;
      mod_clr  <= 1'b1;
      strobe   <= 1'b0;
      underrun <= 1'b0;
`ifdef DSMOD_FEEDER_RAMP_EN
      k        <= K_MAX;
      cur      <= '0;
`endif
    end else begin
      state   <= state_nx;
      mod_clr <= (state_nx == IDLE);
      strobe  <= boundary && (state_nx != IDLE);
      if (state_nx == IDLE) begin
        cnt      <= '0;
        mod_in   <= '0;
        underrun <= 1'b0;
`ifdef DSMOD_FEEDER_RAMP_EN
        cur      <= '0;
`endif
      end else begin
        // Counter stays at 0 on the IDLE exit edge so the first period is a full osr.
        cnt <= (boundary || state == IDLE) ? '0 : cnt + CW'(1);
        if (boundary) begin
`ifdef DSMOD_FEEDER_RAMP_EN
          cur    <= sample_nx;
          mod_in <= ramp_shift(sample_nx, ksh);
`else
          mod_in <= sample_nx;
`endif
        end
        if (boundary && empty && state == RUN) underrun <= 1'b1;
      end
`ifdef DSMOD_FEEDER_RAMP_EN
      k <= k_nx;
`endif
    end
  end

endmodule
